// File: rtl/axis_datasink.sv
// AXI-Stream capture sink: stores a fixed-length burst, throttles tready on a fixed
// period and reports beat/stall counts, a running checksum and a sticky protocol flag.
module axis_datasink #(
    parameter int unsigned xL        = 148,
    parameter int unsigned DW        = 37,
    parameter int unsigned AW        = 11,
    parameter int unsigned BP_PERIOD = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_tvalid,
    input  logic [DW-1:0] i_tdata,
    output logic          o_tready,
    output logic          o_done,
    output logic [AW-1:0] o_beat_cnt,
    output logic [AW-1:0] o_stall_cnt,
    output logic [DW-1:0] o_checksum,
    output logic          o_proto_err,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    localparam int unsigned MW = (xL > 1) ? $clog2(xL) : 1;
    localparam int unsigned BW = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RECV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic          r_tready;
    logic [AW-1:0] r_beat_cnt;
    logic [AW-1:0] r_stall_cnt;
    logic [DW-1:0] r_checksum;
    logic          r_proto_err;
    logic [MW-1:0] r_wr_ptr;
    logic [BW-1:0] r_bp;
    logic          r_pv_stall;
    logic [DW-1:0] r_pv_data;
    logic [DW-1:0] r_rd_data;
    logic [DW-1:0] r_mem [xL];

    logic          w_arm;
    logic          w_xfer;
    logic          w_last;
    logic          w_stall;
    logic [1:0]    w_state_d;
    logic [BW-1:0] w_bp_d;

    assign w_arm  = i_start && (r_state != S_RECV);
    assign w_xfer = (r_state == S_RECV) && i_tvalid && r_tready;
    assign w_last = w_xfer && (r_wr_ptr == MW'(xL - 1));

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_arm) w_state_d = S_RECV;
            S_RECV:         if (w_last) w_state_d = S_DONE;
            default:        w_state_d = S_IDLE;
        endcase
    end

    // Counter only advances in RECV; a stall is scheduled when it is about to hit its last value.
    always_comb begin
        w_bp_d = r_bp;
        if (w_arm) begin
            w_bp_d = '0;
        end else if ((r_state == S_RECV) && (BP_PERIOD >= 2)) begin
            if (r_bp == BW'(BP_PERIOD - 1)) w_bp_d = '0;
            else                            w_bp_d = r_bp + BW'(1);
        end
    end

    assign w_stall = (BP_PERIOD >= 2) && (w_bp_d == BW'(BP_PERIOD - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            r_checksum  <= '0;
            r_proto_err <= 1'b0;
            r_wr_ptr    <= '0;
            r_bp        <= '0;
            r_pv_stall  <= 1'b0;
            r_pv_data   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_tready  <= (w_state_d == S_RECV) && !w_stall;
            r_bp      <= w_bp_d;
            r_pv_data <= i_tdata;
            if (w_arm) begin
                r_beat_cnt  <= '0;
                r_stall_cnt <= '0;
                r_checksum  <= '0;
                r_proto_err <= 1'b0;
                r_wr_ptr    <= '0;
                r_pv_stall  <= 1'b0;
            end else if (r_state == S_RECV) begin
                if (w_xfer) begin
                    r_wr_ptr   <= r_wr_ptr + MW'(1);
                    r_beat_cnt <= r_beat_cnt + AW'(1);
                    r_checksum <= r_checksum + i_tdata;
                end
                if (i_tvalid && !r_tready && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + AW'(1);
                end
                // A stalled beat must be held: valid stays high and data stays put.
                if (r_pv_stall && (!i_tvalid || (i_tdata != r_pv_data))) begin
                    r_proto_err <= 1'b1;
                end
                r_pv_stall <= i_tvalid && !r_tready;
            end else begin
                r_pv_stall <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_xfer) r_mem[r_wr_ptr] <= i_tdata;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_data <= '0;
        end else if (i_rd_addr < AW'(xL)) begin
            r_rd_data <= r_mem[i_rd_addr[MW-1:0]];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign o_tready    = r_tready;
    assign o_done      = (r_state == S_DONE);
    assign o_beat_cnt  = r_beat_cnt;
    assign o_stall_cnt = r_stall_cnt;
    assign o_checksum  = r_checksum;
    assign o_proto_err = r_proto_err;
    assign o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_axis_datasink.sv
// Directed bench for axis_datasink: one unthrottled and one BP_PERIOD=4 instance,
// selected by sel, with a queue scoreboard for captured data.
module tb_axis_datasink;

    localparam int unsigned XL = 148;
    localparam int unsigned DW = 37;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel;
    logic          start;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [AW-1:0] rd_addr;

    logic          t0_tready, t0_done, t0_perr;
    logic [AW-1:0] t0_beat, t0_stall;
    logic [DW-1:0] t0_sum, t0_rd;
    logic          t4_tready, t4_done, t4_perr;
    logic [AW-1:0] t4_beat, t4_stall;
    logic [DW-1:0] t4_sum, t4_rd;

    logic          tready, done, perr;
    logic [AW-1:0] beat, stall;
    logic [DW-1:0] sum, rd_data;

    int total = 0;
    int bad   = 0;
    int q[$];
    int ready_cnt;

    always #5 clk = ~clk;

    axis_datasink #(.xL(XL), .DW(DW), .AW(AW), .BP_PERIOD(0)) u_bp0 (
        .i_clk(clk), .i_reset(reset), .i_start(start & ~sel), .i_tvalid(tvalid & ~sel),
        .i_tdata(tdata), .o_tready(t0_tready), .o_done(t0_done), .o_beat_cnt(t0_beat),
        .o_stall_cnt(t0_stall), .o_checksum(t0_sum), .o_proto_err(t0_perr),
        .i_rd_addr(rd_addr), .o_rd_data(t0_rd)
    );

    axis_datasink #(.xL(XL), .DW(DW), .AW(AW), .BP_PERIOD(4)) u_bp4 (
        .i_clk(clk), .i_reset(reset), .i_start(start & sel), .i_tvalid(tvalid & sel),
        .i_tdata(tdata), .o_tready(t4_tready), .o_done(t4_done), .o_beat_cnt(t4_beat),
        .o_stall_cnt(t4_stall), .o_checksum(t4_sum), .o_proto_err(t4_perr),
        .i_rd_addr(rd_addr), .o_rd_data(t4_rd)
    );

    assign tready  = sel ? t4_tready : t0_tready;
    assign done    = sel ? t4_done   : t0_done;
    assign perr    = sel ? t4_perr   : t0_perr;
    assign beat    = sel ? t4_beat   : t0_beat;
    assign stall   = sel ? t4_stall  : t0_stall;
    assign sum     = sel ? t4_sum    : t0_sum;
    assign rd_data = sel ? t4_rd     : t0_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Well-behaved source: holds data while stalled, advances only on accepted beats.
    task automatic stream(input int n, input int base, input bit chk_pat, input int start_at);
        int d       = 0;
        int k       = 0;
        int pat_bad = 0;
        bit sent    = 1'b0;
        ready_cnt = 0;
        while (d < n && k < 1000) begin
            tvalid = 1'b1;
            tdata  = DW'(base + d);
            start  = 1'b0;
            if (d == start_at && !sent) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            if (chk_pat && (tready !== logic'((k % 4) != 3))) pat_bad++;
            if (tready === 1'b1) begin
                q.push_back(base + d);
                d++;
                ready_cnt++;
            end
            k++;
            tick();
        end
        tvalid = 1'b0;
        start  = 1'b0;
        chk("stream_len", d, n);
        if (chk_pat) chk("tready_pattern_errs", pat_bad, 0);
    endtask

    task automatic readback(input int n);
        chk("sb_depth", q.size(), n);
        for (int a = 0; a < n; a++) begin
            rd_addr = AW'(a);
            tick();
            chk("rd_data", rd_data, (q.size() > 0) ? q.pop_front() : -1);
        end
    endtask

    task automatic wait_stall();
        int w = 0;
        while (tready !== 1'b0 && w < 8) begin
            tick();
            w++;
        end
        chk("stall_seen", tready, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; start = 1'b0; tvalid = 1'b0; tdata = '0; rd_addr = '0; reset = 1'b1;
        repeat (3) tick();
        chk("rst_tready", tready, 0);
        chk("rst_done", done, 0);
        chk("rst_beat", beat, 0);
        chk("rst_stall", stall, 0);
        chk("rst_sum", sum, 0);
        chk("rst_perr", perr, 0);
        chk("rst_rd", rd_data, 0);
        reset = 1'b0;
        tick();

        // Valid data before start must be ignored.
        tvalid = 1'b1; tdata = DW'(1);
        repeat (3) tick();
        chk("idle_tready", tready, 0);
        chk("idle_beat", beat, 0);
        chk("idle_stall", stall, 0);
        chk("idle_done", done, 0);
        tvalid = 1'b0;

        // Unthrottled capture.
        q.delete();
        do_start();
        chk("t1_tready_rise", tready, 1);
        stream(148, 0, 1'b0, -1);
        chk("t1_ready_edges", ready_cnt, 148);
        chk("t1_done", done, 1);
        chk("t1_tready_low", tready, 0);
        chk("t1_beat", beat, 148);
        chk("t1_stall", stall, 0);
        chk("t1_sum", sum, 10878);
        chk("t1_perr", perr, 0);
        tvalid = 1'b1; tdata = DW'(999);
        repeat (3) tick();
        chk("t1_no_extra_beat", beat, 148);
        chk("t1_no_extra_sum", sum, 10878);
        tvalid = 1'b0;
        rd_addr = AW'(5);
        tick();
        chk("t1_rd5", rd_data, 5);
        readback(148);

        // start in RECV is ignored.
        q.delete();
        do_start();
        stream(148, 0, 1'b0, 10);
        chk("ign_beat", beat, 148);
        chk("ign_sum", sum, 10878);
        chk("ign_done", done, 1);

        // Throttled capture.
        sel = 1'b1;
        q.delete();
        do_start();
        stream(148, 0, 1'b1, -1);
        chk("bp_done", done, 1);
        chk("bp_beat", beat, 148);
        chk("bp_stall", stall, 49);
        chk("bp_sum", sum, 10878);
        chk("bp_perr", perr, 0);
        readback(148);

        // Violation: valid dropped while stalled.
        do_start();
        wait_stall();
        tvalid = 1'b1; tdata = DW'(7);
        tick();
        chk("perr_pre_drop", perr, 0);
        tvalid = 1'b0;
        tick();
        chk("perr_drop", perr, 1);
        repeat (3) tick();
        chk("perr_sticky", perr, 1);
        stream(148, 0, 1'b0, -1);
        chk("perr_at_done", perr, 1);
        do_start();
        chk("perr_clear", perr, 0);

        // Violation: data changed while stalled.
        wait_stall();
        tvalid = 1'b1; tdata = DW'(7);
        tick();
        chk("perr_pre_chg", perr, 0);
        tdata = DW'(9);
        tick();
        tvalid = 1'b0;
        chk("perr_chg", perr, 1);
        stream(147, 100, 1'b0, -1);
        chk("perr_chg_done", perr, 1);
        do_start();
        chk("perr_chg_clear", perr, 0);

        // Reset mid-capture, then a full clean capture.
        sel = 1'b0;
        q.delete();
        do_start();
        stream(50, 0, 1'b0, -1);
        chk("mid_beat", beat, 50);
        reset = 1'b1;
        #1;
        chk("async_tready", tready, 0);
        chk("async_beat", beat, 0);
        chk("async_sum", sum, 0);
        chk("async_done", done, 0);
        tick();
        reset = 1'b0;
        tick();
        q.delete();
        do_start();
        stream(148, 0, 1'b0, -1);
        chk("rs_done", done, 1);
        chk("rs_beat", beat, 148);
        chk("rs_stall", stall, 0);
        chk("rs_sum", sum, 10878);
        chk("rs_perr", perr, 0);
        readback(148);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_datasink.md
Name: axis_datasink

Overview:
- AXI-Stream sink; the receiving end of the team's stream sources (datasrc and similar).
- Accepts a fixed-length burst of xL beats into internal memory.
- Generates a parameterised tready back-pressure pattern to exercise source stall handling.
- Reports beat count, stall count, a running checksum and a sticky protocol-violation flag. Captured data is readable through a synchronous readback port.

Parameters:
- xL, 148, number of beats per capture; memory depth.
- DW, 37, tdata width.
- AW, 11, address and counter width; requires 2^AW > xL.
- BP_PERIOD, 0, back-pressure period. 0 means tready is never throttled. N>=2 means tready is low one cycle in every N.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse that arms a capture.
- tvalid  input  1  AXI-S valid from source.
- tdata  input  DW  AXI-S data from source.
- tready  output  1  AXI-S ready; registered.
- done  output  1  high once xL beats are captured.
- beat_cnt  output  AW  beats accepted in the current capture.
- stall_cnt  output  AW  cycles in RECV with tvalid=1 and tready=0; saturates at all-ones.
- checksum  output  DW  sum of accepted tdata, modulo 2^DW.
- proto_err  output  1  sticky stream-rule violation flag.
- rd_addr  input  AW  readback address.
- rd_data  output  DW  mem[rd_addr]; one-cycle latency.

Behaviour:
- Reset (asynchronous): state=IDLE. tready, done, proto_err=0. beat_cnt, stall_cnt, checksum, rd_data, write pointer and bp counter=0. Memory contents are not reset.
- Transfer: occurs on a rising edge where tvalid=1 and tready=1. On each transfer:
  - mem[wr_ptr] <= tdata;
  - wr_ptr and beat_cnt increment;
  - checksum <= checksum + tdata, truncated to DW.
- States:
  - IDLE: tready=0. start moves to RECV and clears beat_cnt, stall_cnt, checksum, wr_ptr, bp counter and proto_err.
  - RECV: capture. When a transfer happens with wr_ptr=xL-1, go to DONE.
  - DONE: tready=0, done=1. start behaves exactly as in IDLE, clears done, and enters RECV.
  - start while in RECV is ignored.
- tready is registered from next-state values: n_tready = (n_state==RECV) && !n_stall.
  - tready rises the cycle after start is sampled.
  - tready falls on the same edge that accepts the last beat, so a beat xL+1 is never accepted.
- Back-pressure:
  - bp counter runs 0..BP_PERIOD-1 while in RECV and wraps.
  - n_stall=1 when the counter's next value is BP_PERIOD-1.
  - For BP_PERIOD=4 this gives the repeating tready pattern 1,1,1,0 from the first RECV cycle.
  - BP_PERIOD=0 forces n_stall=0.
- stall_cnt increments in RECV only, and only on cycles with tvalid=1 and tready=0. It saturates and does not wrap.
- proto_err is set in RECV if the previous cycle had tvalid=1 and tready=0, and the current cycle has either tvalid=0 or tdata different from the previous tdata. It stays set until start or reset.
- tvalid in IDLE/DONE: no transfer, no counting, no error checking.
- done stays high in DONE until start or reset.
- rd_data <= mem[rd_addr] every cycle in every state. rd_addr >= xL returns an undefined value.
- Simultaneous write and read of the same address: rd_data returns the old contents.
- reset mid-capture aborts immediately: tready drops asynchronously and state returns to IDLE; memory keeps its partial contents.

Test Plan:
- BP_PERIOD=0, start, source streams 0..147 continuously:
  - tready=1 for exactly 148 edges;
  - done=1 the cycle after the last beat;
  - beat_cnt=148, stall_cnt=0, checksum=10878;
  - rd_addr=5 returns 5 one cycle later.
- BP_PERIOD=4, tvalid held high, data 0..147:
  - tready pattern 1,1,1,0 repeating;
  - capture completes with stall_cnt=49;
  - memory contents identical to the first test; proto_err=0.
- Source drops tvalid, and separately changes tdata from 7 to 9, while tready=0 and tvalid=1 -> proto_err=1 the following cycle; it stays 1 until the next start, then clears.
- tvalid=1 with data 0x1 before start -> tready=0, beat_cnt=0, stall_cnt=0.
- start pulses in RECV after beat 10 -> ignored; beat_cnt keeps counting to 148.
- Assert reset after beat 50, release, start, stream 148 beats -> all outputs restart from 0 and the final counts match the first test.
